// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: trapezoidal step sequencer with abort decel.
// cmd_* handshake in, step_pulse/step_dir/step_half/pos/speed_sps out.
module stepper_move_ctrl #(
  parameter int unsigned CLK_HZ  = 125_000_000,
  parameter int unsigned MIN_SPS = 100,
  parameter int unsigned MAX_SPS = 600,
  parameter int unsigned ACC_SPS = 50,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned POS_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic              abort,
  output logic              step_pulse,
  output logic              step_dir,
  output logic              step_half,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  pos,
  output logic [31:0]       speed_sps
);

  localparam int unsigned RMAX =
    (MAX_SPS - MIN_SPS) / ACC_SPS;
  localparam int unsigned R_W =
    (RMAX < 2) ? 2 : $clog2(RMAX + 1);

  localparam logic [R_W-1:0]    RMAX_R   = R_W'(RMAX);
  localparam logic [R_W-1:0]    R_ONE    = R_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
  localparam logic [31:0]       CLK_32   = CLK_HZ;
  localparam logic [32:0]       CLK_33   = {1'b0, CLK_32};
  localparam logic [31:0]       MIN_32   = MIN_SPS;
  localparam logic [31:0]       ACC_32   = ACC_SPS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [31:0]       acc, acc_n;
  logic [R_W-1:0]    r, r_n;
  logic [STEP_W-1:0] rem, rem_n;
  logic [POS_W-1:0]  pos_n;
  logic              dir_n, half_n;
  logic              pulse_n, done_n;

  logic [31:0]       sps;
  logic [32:0]       sum;
  logic [STEP_W-1:0] rem_dec;
  logic              stop_mode;
  logic              fin;

  assign sps     = MIN_32 + ACC_32 * 32'(r);
  assign sum     = {1'b0, acc} + {1'b0, sps};
  assign rem_dec = rem - STEP_ONE;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign speed_sps = busy ? sps : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      r          <= '0;
      rem        <= '0;
      pos        <= '0;
      step_dir   <= 1'b0;
      step_half  <= 1'b0;
      step_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      r          <= r_n;
      rem        <= rem_n;
      pos        <= pos_n;
      step_dir   <= dir_n;
      step_half  <= half_n;
      step_pulse <= pulse_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    r_n       = r;
    rem_n     = rem;
    pos_n     = pos;
    dir_n     = step_dir;
    half_n    = step_half;
    pulse_n   = 1'b0;
    done_n    = 1'b0;
    stop_mode = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_n  = cmd_dir;
          half_n = cmd_half;
          rem_n  = cmd_steps;
          acc_n  = '0;
          r_n    = '0;
          if (cmd_steps == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN, STOP: begin
        // an abort seen on a step edge already decels that step
        stop_mode = (state == STOP) || abort;
        if (state == RUN && abort) begin
          state_n = STOP;
        end
        if (sum >= CLK_33) begin
          // wrap of the low word is exact since sum < 2*CLK_HZ
          acc_n   = sum[31:0] - CLK_32;
          pulse_n = 1'b1;
          rem_n   = rem_dec;
          pos_n   = step_dir ? pos + POS_ONE
                             : pos - POS_ONE;
          if (rem_dec == '0) begin
            fin = 1'b1;
          end else if (stop_mode) begin
            if (r == '0) begin
              fin = 1'b1;
            end else begin
              r_n = r - R_ONE;
            end
          end else if (32'(rem_dec) <= 32'(r)) begin
            r_n = r - R_ONE;
          end else if (r < RMAX_R) begin
            r_n = r + R_ONE;
          end
          if (fin) begin
            done_n  = 1'b1;
            state_n = IDLE;
            r_n     = '0;
          end
        end else begin
          acc_n = sum[31:0];
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb_stepper_move_ctrl: scoreboard bench with an event-level model.
// Stimulus pushes expected step/done events; a monitor pops them.
module tb_stepper_move_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int MIN_SPS = 100;
  localparam int MAX_SPS = 500;
  localparam int ACC_SPS = 100;
  localparam int RMAX    = (MAX_SPS - MIN_SPS) / ACC_SPS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        cmd_half = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        cmd_ready, step_pulse, step_dir, step_half;
  logic        busy, done;
  logic [23:0] pos;
  logic [31:0] speed_sps;

  stepper_move_ctrl #(
    .CLK_HZ (CLK_HZ),
    .MIN_SPS(MIN_SPS),
    .MAX_SPS(MAX_SPS),
    .ACC_SPS(ACC_SPS),
    .STEP_W (16),
    .POS_W  (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_half  (cmd_half),
    .abort     (abort),
    .step_pulse(step_pulse),
    .step_dir  (step_dir),
    .step_half (step_half),
    .busy      (busy),
    .done      (done),
    .pos       (pos),
    .speed_sps (speed_sps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          pulse;
    bit          fin;
    logic [23:0] pos;
    int          speed;
    bit          dir;
    bit          half;
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          npulse = 0;
  int          errors = 0;
  int          checks = 0;
  logic [23:0] mpos = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Event-level reference: each step is found by solving how many
  // edges the accumulated rate needs to cross CLK_HZ.
  task automatic push_model(int a, int n, bit dir, bit half, int e);
    ev_t ev;
    int  acc, r, t, rem, sps, k;
    bit  fin;
    ev.dir  = dir;
    ev.half = half;
    if (n == 0) begin
      ev.cyc = a; ev.pulse = 0; ev.fin = 1;
      ev.pos = mpos; ev.speed = 0;
      q.push_back(ev);
      return;
    end
    acc = 0; r = 0; t = a; rem = n;
    do begin
      sps = MIN_SPS + r * ACC_SPS;
      k   = (CLK_HZ - acc + sps - 1) / sps;
      t   = t + k;
      acc = acc + k * sps - CLK_HZ;
      mpos = dir ? mpos + 24'd1 : mpos - 24'd1;
      rem--;
      fin = 0;
      if (rem == 0) fin = 1;
      else if (e > a && t >= e) begin
        if (r == 0) fin = 1;
        else r--;
      end
      else if (rem <= r) r--;
      else if (r < RMAX) r++;
      if (fin) r = 0;
      ev.cyc = t; ev.pulse = 1; ev.fin = fin;
      ev.pos = mpos;
      ev.speed = fin ? 0 : MIN_SPS + r * ACC_SPS;
      q.push_back(ev);
    end while (!fin);
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (rst_n && (step_pulse || done)) begin
      if (step_pulse) npulse++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: pulse=%0b done=%0b cyc %0d, none expected",
                 step_pulse, done, cyc);
      end else begin
        ev = q.pop_front();
        chk("event_cycle", cyc, ev.cyc);
        chk("step_pulse", step_pulse, ev.pulse);
        chk("done", done, ev.fin);
        chk("pos", pos, ev.pos);
        chk("speed_sps", speed_sps, ev.speed);
        chk("step_dir", step_dir, ev.dir);
        chk("step_half", step_half, ev.half);
        chk("busy", busy, !ev.fin);
        chk("cmd_ready", cmd_ready, ev.fin);
      end
    end
  end

  task automatic issue(int n, bit dir, bit half, int e_off,
                       output int a);
    chk("ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = 16'(n);
    cmd_dir   = dir;
    cmd_half  = half;
    a = cyc + 1;
    push_model(a, n, dir, half, (e_off > 0) ? a + e_off : -1);
  endtask

  task automatic run_move(int n, bit dir, bit half, int e_off,
                          int ghost, output int post);
    int a, e, base;
    bit ok;
    ok = 0;
    base = -1;
    issue(n, dir, half, e_off, a);
    e = (e_off > 0) ? a + e_off : -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      if (e > 0 && cyc == e - 1) begin
        abort = 1'b1;
        base  = npulse;
      end
      if (ghost > 0 && cyc == a + ghost) begin
        chk("ready_while_busy", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_steps = 16'd5;
      end
      if (q.size() == 0 && !abort && !cmd_valid) begin
        ok = 1;
        break;
      end
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL move_timeout: %0d events left, 0 required",
               q.size());
      q.delete();
    end
    post = (base < 0) ? 0 : npulse - base;
  endtask

  initial begin
    int pa, base, a;
    bit hit;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_step_pulse", step_pulse, 0);
    chk("rst_step_dir", step_dir, 0);
    chk("rst_step_half", step_half, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", pos, 0);
    chk("rst_speed", speed_sps, 0);
    rst_n = 1'b1;

    base = npulse;
    repeat (100) @(negedge clk);
    #1;
    chk("idle_no_pulse", npulse - base, 0);

    run_move(3, 1'b1, 1'b0, 0, 0, pa);
    chk("pos_after_3", pos, 3);

    run_move(20, 1'b0, 1'b1, 0, 30, pa);
    chk("pos_after_20", pos, 24'hFFFFEF);

    run_move(1000, 1'b1, 1'b0, 22, 0, pa);
    chk("abort_pulses", pa, 5);
    chk("pos_after_abort", pos, mpos);

    run_move(0, 1'b0, 1'b0, 0, 0, pa);
    chk("pos_after_zero", pos, mpos);

    base = npulse;
    abort = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_pulses", npulse - base, 0);

    issue(50, 1'b1, 1'b0, 0, a);
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      cmd_valid = 1'b0;
      if (speed_sps == 32'd300) begin
        hit = 1;
        break;
      end
    end
    chk("reached_r2", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulse", step_pulse, 0);
    chk("mid_rst_dir", step_dir, 0);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_speed", speed_sps, 0);
    q.delete();
    mpos = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    base = npulse;
    repeat (50) @(negedge clk);
    #1;
    chk("post_rst_no_pulse", npulse - base, 0);
    run_move(3, 1'b1, 1'b1, 0, 0, pa);
    chk("pos_after_rst_move", pos, 3);

    for (int j = 0; j < 12; j++) begin
      int n, eo;
      n  = $urandom_range(0, 40);
      eo = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : 0;
      run_move(n, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), eo, 0, pa);
      chk("rand_pos", pos, mpos);
    end

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
# stepper_move_ctrl

Trapezoidal-profile move sequencer for the Zybo stepper path. It accepts a move command (step count, direction, half/full mode) through a valid/ready handshake. It then emits single-cycle step pulses whose rate ramps from MIN_SPS up to MAX_SPS and back down, and supports a controlled-decel abort. It sits between the command source (switch/PS logic) and the coil-pattern indexer, which advances one index per step_pulse, and it tracks absolute position.

## Interface
- CLK_HZ, 125_000_000: clk frequency in Hz.
- MIN_SPS, 100: start/stop step rate (steps/s).
- MAX_SPS, 600: cruise step rate; (MAX_SPS-MIN_SPS) must be divisible by ACC_SPS.
- ACC_SPS, 50: rate change per step; RMAX = (MAX_SPS-MIN_SPS)/ACC_SPS.
- STEP_W, 16: width of step count.
- POS_W, 24: width of signed position.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high when idle; a command is accepted on an edge with cmd_valid & cmd_ready.
- cmd_steps  in  STEP_W  number of steps to move.
- cmd_dir  in  1  1 = forward (+), 0 = reverse (−).
- cmd_half  in  1  half-step mode flag, latched and passed through.
- abort  in  1  request controlled deceleration to stop.
- step_pulse  out  1  one-cycle step strobe to the indexer.
- step_dir  out  1  latched direction.
- step_half  out  1  latched half/full mode.
- busy  out  1  move in progress.
- done  out  1  one-cycle end-of-move strobe.
- pos  out  POS_W  signed absolute position, two's complement.
- speed_sps  out  32  current rate MIN_SPS + r·ACC_SPS; 0 when idle.

## Operation
- Registers: acc (32 b phase accumulator), r (ramp index, 0..RMAX), rem (STEP_W), state.
- States:
  - IDLE: cmd_ready=1.
  - RUN: normal profile.
  - STOP: abort deceleration.
- IDLE, on accept:
  - Latch cmd_dir and cmd_half into step_dir and step_half; set rem=cmd_steps, acc=0, r=0.
  - cmd_steps=0: stay IDLE and pulse done on the next edge. No step is issued.
  - cmd_steps≠0: go to RUN.
- RUN/STOP, every edge:
  - Compute sum = acc + sps.
  - If sum ≥ CLK_HZ: issue a step, with step_pulse=1 for the following cycle and acc ← sum − CLK_HZ.
  - Otherwise acc ← sum.
- On each issued step:
  - pos ± 1 according to step_dir; pos wraps modulo 2^POS_W.
  - rem' = rem − 1.
  - If rem' = 0: done=1 (same cycle as that step_pulse), go to IDLE, r=0.
  - RUN rule: if rem' ≤ r then r−1; else if r < RMAX then r+1; else hold.
  - STOP rule: if r = 0 then done and go to IDLE; else r−1.
- Abort:
  - Sampled high in RUN: go to STOP at that edge. If a step also occurs on that edge, the STOP rule is applied to it.
  - Ignored in IDLE and STOP.
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.
- busy = (state ≠ IDLE). cmd_ready = !busy.

## Timing
- Reset values:
  - cmd_ready=1.
  - busy=0, step_pulse=0, step_dir=0, step_half=0, done=0.
  - pos=0, speed_sps=0.
  - acc=0, r=0, rem=0, state=IDLE.
- Reset asserted mid-move aborts immediately, with no further pulses. All outputs return to their reset values asynchronously, including pos.
- Step interval (exact on average): CLK_HZ/sps edges; the fractional remainder is carried in acc.
- First step_pulse is asserted ceil(CLK_HZ/MIN_SPS) edges after the accept edge.
- busy falls and cmd_ready rises in the same cycle as done. A new command may be accepted on the next edge.
- step_pulse is never high for two consecutive cycles while sps ≤ CLK_HZ/2.
- speed_sps reflects r updated at the step edge.

## Test plan
All scenarios use CLK_HZ=1000, MIN_SPS=100, MAX_SPS=500, ACC_SPS=100 (RMAX=4).
- Reset check: rst_n low, then release → cmd_ready=1, all other outputs 0. With no command, there is no step_pulse for 100 cycles.
- cmd_steps=3, dir=1 → pulses at +10, then +5, then +10 edges after the accept edge. Rates are 100, 200, 100; done coincides with the 3rd pulse; pos=3.
- cmd_steps=20, dir=0, from pos=3:
  - Ramp visits 100..500, cruises at 2-cycle intervals, then decelerates symmetrically.
  - Exactly 20 pulses, done once, pos=−17.
  - cmd_valid pulsed mid-move is ignored.
- cmd_steps=1000, abort during cruise (r=4, no coincident step) → exactly 5 further pulses at 500/400/300/200/100 sps. Then done; pos reflects the true count.
- cmd_steps=0 → done on the next cycle, no step_pulse, pos unchanged. abort in IDLE has no effect.
- Reset mid-move at r=2 → outputs at reset values immediately, no step_pulse afterwards. A new command afterwards starts from MIN_SPS.
